audio_frame_buffer: RTL and testbench
=====================================

# audio_frame_buffer

Parametrised multi-channel audio capture buffer between the MainGameBoy audio outputs and the Display waveform renderer. Replaces the single-stage stored-sample register pair with N channels of W-bit samples, run-time power-of-two decimation, a DEPTH-frame FIFO and a valid/ready read port. It also adds a freeze control, so the display can hold a stable snapshot while frames already buffered keep draining.

## Interface
- CHANNELS, 2: number of audio channels; channel 0 is in the LSBs of every packed bus.
- WIDTH, 24: bits per sample, two's complement.
- DEPTH, 512: FIFO depth in frames; must be a power of two, at least 2.
- MAX_DECIM_LOG2, 8: largest accepted decim_log2 value.

- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- in_samples  in  CHANNELS*WIDTH  packed input samples.
- in_strobe  in  1  in_samples valid this cycle.
- decim_log2  in  4  decimation window = 2^decim_log2 strobes; values above MAX_DECIM_LOG2 clamp to MAX_DECIM_LOG2.
- freeze  in  1  ignore input and discard any partial window.
- clr_overflow  in  1  clears the overflow flag.
- out_data  out  CHANNELS*WIDTH  frame at the FIFO head.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the frame; a pop happens when out_valid && out_ready.
- level  out  $clog2(DEPTH)+1  frames accepted and not yet popped.
- overflow  out  1  sticky flag for a dropped frame.

## Operation
- Reset values: out_data=0, out_valid=0, level=0, overflow=0, window counter=0, accumulator=0.
- Window counter counts only the strobes accepted while freeze=0.
- The effective decimation value d is latched on the first accepted strobe of each window (counter==0). Changes to decim_log2 take effect only at window boundaries.
- A frame completes on the strobe where counter == 2^d−1. On that strobe the counter wraps to 0. With d=0, every accepted strobe completes a frame.
- Frame contents without averaging: the samples of the completing strobe.
- freeze=1:
  - in_strobe is ignored, the counter clears to 0 and any accumulator content is discarded.
  - Reads, pops and level updates continue.
- FIFO push:
  - A completed frame is written if level<DEPTH, or if a pop happens in the same cycle.
  - Otherwise the frame is dropped and overflow is set.
- overflow is cleared only by reset or clr_overflow. If clr_overflow and a new drop occur in the same cycle, the set wins.
- level changes by +1 on a push alone, −1 on a pop alone, and is unchanged on a simultaneous push and pop.
- Frames leave the FIFO in order. out_data holds steady while out_valid=1 and out_ready=0.
- Reset mid-operation clears all state on the next edge, including FIFO contents, the partial window and overflow.

## Timing
- Latency from the completing in_strobe at edge t to an empty FIFO showing out_valid=1: out_valid is high in the cycle after edge t+1 (2 edges). With AUDIO_BUF_AVG_EN the latency is 3 edges.
- Back-to-back pops with out_ready held high sustain 1 frame/cycle.
- After a pop at edge t, the next frame (if one is stored) is presented from edge t onward with no bubble.
- in_strobe may be high on every cycle; the block never applies back-pressure to the input.

## Configuration
- AUDIO_BUF_AVG_EN defined:
  - Each channel keeps a signed accumulator of WIDTH+MAX_DECIM_LOG2 bits, summed over the whole window.
  - The frame value is the sum arithmetically shifted right by d and truncated to WIDTH bits.
  - One extra pipeline register is added, giving 3-edge latency.
- AUDIO_BUF_AVG_EN undefined: no accumulators; the frame is the last sample of the window, with 2-edge latency.

## Test plan
All scenarios use CHANNELS=2, WIDTH=24, DEPTH=4.
- Pass-through: d=0, out_ready=1, strobes with ch0=0x000001..0x000003 and ch1=0xFFFFFF → frames emerge in order, out_valid high exactly 2 edges after each strobe, level returns to 0.
- Decimation: d=2, ch0 samples 4, 8, 0xFFFFFC, 0 → without AVG one frame ch0=0x000000; with AVG ch0=0x000002 (sum 8 >> 2). No frame is emitted before the 4th strobe.
- Overflow: out_ready=0, d=0, 5 strobes with values 1..5 → level=4, overflow=1. Drain returns 1, 2, 3, 4. clr_overflow → overflow=0.
- Full with simultaneous pop: level=4, strobe in the same cycle as a pop → level stays 4, overflow stays 0, new frame is last in order.
- Freeze: d=2, 2 strobes, then freeze for 3 cycles with strobes, then 4 strobes → exactly one frame, built only from the last 4 samples.
- Reset mid-window: d=3, 5 strobes, level=2, reset pulse → next cycle out_valid=0, level=0, overflow=0. The next 8 strobes produce exactly one frame.

Source files
------------

// File: rtl/audio_frame_buffer.sv
// audio_frame_buffer: N-channel decimating audio capture FIFO with freeze and valid/ready read port; AUDIO_BUF_AVG_EN enables window averaging
module audio_frame_buffer #(
    parameter int CHANNELS       = 2,
    parameter int WIDTH          = 24,
    parameter int DEPTH          = 512,
    parameter int MAX_DECIM_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_samples,
    input  logic                      in_strobe,
    input  logic [3:0]                decim_log2,
    input  logic                      freeze,
    input  logic                      clr_overflow,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);
    localparam int CW = CHANNELS * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [3:0] DMAX = 4'(MAX_DECIM_LOG2);

    logic [MAX_DECIM_LOG2-1:0] r_cnt;
    logic [MAX_DECIM_LOG2-1:0] w_mask;
    logic [3:0]                r_d;
    logic [3:0]                w_d;
    logic                      w_acc_en;
    logic                      w_done;
    logic [CW-1:0]             r_frm;
    logic                      r_frm_valid;

    // d is re-evaluated only at window start; mid-window the latched value holds
    assign w_acc_en = in_strobe && !freeze;
    assign w_d      = (r_cnt == '0) ? ((decim_log2 > DMAX) ? DMAX : decim_log2) : r_d;
    assign w_mask   = ~({MAX_DECIM_LOG2{1'b1}} << w_d);
    assign w_done   = w_acc_en && (r_cnt == w_mask);

    // window counter; freeze discards the partial window
    always_ff @(posedge clk) begin
        if (reset || freeze) begin
            r_cnt <= '0;
            r_d   <= '0;
        end else if (w_acc_en) begin
            r_cnt <= w_done ? '0 : r_cnt + 1'b1;
            r_d   <= w_d;
        end
    end

`ifdef AUDIO_BUF_AVG_EN
    localparam int SW = WIDTH + MAX_DECIM_LOG2;

    logic signed [SW-1:0] r_acc [CHANNELS];
    logic signed [SW-1:0] w_sum [CHANNELS];
    logic signed [SW-1:0] r_sum [CHANNELS];
    logic [3:0]           r_sum_d;
    logic                 r_sum_valid;

    // running sum including this strobe; a window start drops the old total
    always_comb begin
        for (int c = 0; c < CHANNELS; c++)
            w_sum[c] = ((r_cnt == '0) ? SW'(0) : r_acc[c]) + SW'($signed(in_samples[c*WIDTH +: WIDTH]));
    end

    // per-channel accumulators
    always_ff @(posedge clk) begin
        if (reset || freeze) begin
            for (int c = 0; c < CHANNELS; c++)
                r_acc[c] <= '0;
        end else if (w_acc_en) begin
            for (int c = 0; c < CHANNELS; c++)
                r_acc[c] <= w_sum[c];
        end
    end

    // capture the completed window sum with its decimation value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum_valid <= 1'b0;
            r_sum_d     <= '0;
            for (int c = 0; c < CHANNELS; c++)
                r_sum[c] <= '0;
        end else begin
            r_sum_valid <= w_done;
            if (w_done) begin
                r_sum_d <= w_d;
                for (int c = 0; c < CHANNELS; c++)
                    r_sum[c] <= w_sum[c];
            end
        end
    end

    // divide by the window length and truncate to sample width
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frm_valid <= 1'b0;
            r_frm       <= '0;
        end else begin
            r_frm_valid <= r_sum_valid;
            if (r_sum_valid) begin
                for (int c = 0; c < CHANNELS; c++)
                    r_frm[c*WIDTH +: WIDTH] <= WIDTH'(r_sum[c] >>> r_sum_d);
            end
        end
    end
`else
    // the frame is simply the samples of the completing strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frm_valid <= 1'b0;
            r_frm       <= '0;
        end else begin
            r_frm_valid <= w_done;
            if (w_done)
                r_frm <= in_samples;
        end
    end
`endif

    logic [CW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [LW-1:0] r_level;
    logic          r_ovf;
    logic          w_pop;
    logic          w_push;

    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign out_valid = (r_level != '0);
    assign out_data  = out_valid ? r_mem[r_rd] : '0;
    assign level     = r_level;
    assign overflow  = r_ovf;
    assign w_pop     = out_valid && out_ready;
    assign w_push    = r_frm_valid && ((r_level != LW'(DEPTH)) || w_pop);

    // frame storage; stale entries are unreachable once pointers reset
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= r_frm;
    end

    // pointers, occupancy and sticky overflow (set beats clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (r_frm_valid && !w_push)
                r_ovf <= 1'b1;
            else if (clr_overflow)
                r_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_frame_buffer.sv
// tb_audio_frame_buffer: directed scoreboard bench for audio_frame_buffer (2 channels, 24 bit, depth 4)
module tb_audio_frame_buffer;
`ifdef AUDIO_BUF_AVG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] in_samples = '0;
    logic        in_strobe = 1'b0;
    logic [3:0]  decim_log2 = '0;
    logic        freeze = 1'b0;
    logic        clr_overflow = 1'b0;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  level;
    logic        overflow;
    int          total = 0;
    int          bad = 0;
    logic [47:0] exp_q [$];

    audio_frame_buffer #(.CHANNELS(2), .WIDTH(24), .DEPTH(4), .MAX_DECIM_LOG2(8)) dut (
        .clk(clk), .reset(reset), .in_samples(in_samples), .in_strobe(in_strobe),
        .decim_log2(decim_log2), .freeze(freeze), .clr_overflow(clr_overflow),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [47:0] fr(input logic [23:0] c0, input logic [23:0] c1);
        return {c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [23:0] c0, input logic [23:0] c1);
        in_samples = fr(c0, c1);
        in_strobe  = 1'b1;
        tick();
        in_strobe  = 1'b0;
    endtask

    // every frame accepted by the consumer must be the next one the scoreboard expects
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                chk("extra_frame", 64'(exp_q.size()), 64'd1);
            else
                chk("frame", 64'(out_data), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        out_ready = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            exp_q.push_back(fr(24'(v), 24'hFFFFFF));
            strobe(24'(v), 24'hFFFFFF);
            repeat (LAT - 1) begin
                @(negedge clk);
                chk("pass_early", 64'(out_valid), 64'd0);
                tick();
            end
            @(negedge clk);
            chk("pass_latency", 64'(out_valid), 64'd1);
            tick();
            @(negedge clk);
            chk("pass_level", 64'(level), 64'd0);
        end

        decim_log2 = 4'd2;
        strobe(24'h000004, 24'h10);
        strobe(24'h000008, 24'h20);
        strobe(24'hFFFFFC, 24'h30);
        repeat (LAT) tick();
        @(negedge clk);
        chk("decim_early", 64'(out_valid), 64'd0);
`ifdef AUDIO_BUF_AVG_EN
        exp_q.push_back(fr(24'h2, 24'h28));
`else
        exp_q.push_back(fr(24'h0, 24'h40));
`endif
        tick();
        strobe(24'h000000, 24'h40);
        repeat (LAT + 2) tick();
        chk("decim_drain", 64'(exp_q.size()), 64'd0);
        chk("decim_level", 64'(level), 64'd0);

        decim_log2 = 4'd0;
        out_ready  = 1'b0;
        for (int v = 1; v <= 4; v++)
            exp_q.push_back(fr(24'(v), 24'h0));
        for (int v = 1; v <= 5; v++)
            strobe(24'(v), 24'h0);
        repeat (LAT) tick();
        @(negedge clk);
        chk("ovf_level", 64'(level), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        tick();
        out_ready = 1'b1;
        repeat (6) tick();
        chk("ovf_drain", 64'(exp_q.size()), 64'd0);
        chk("ovf_level0", 64'(level), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        @(negedge clk);
        chk("ovf_clear", 64'(overflow), 64'd0);
        tick();

        out_ready = 1'b0;
        for (int v = 'h11; v <= 'h15; v++)
            exp_q.push_back(fr(24'(v), 24'h0));
        for (int v = 'h11; v <= 'h14; v++)
            strobe(24'(v), 24'h0);
        repeat (LAT) tick();
        @(negedge clk);
        chk("full_level", 64'(level), 64'd4);
        tick();
        in_samples = fr(24'h15, 24'h0);
        in_strobe  = 1'b1;
        tick();
        in_strobe  = 1'b0;
        repeat (LAT - 2) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("full_pop_level", 64'(level), 64'd4);
        chk("full_pop_ovf", 64'(overflow), 64'd0);
        tick();
        out_ready = 1'b1;
        repeat (6) tick();
        chk("full_order", 64'(exp_q.size()), 64'd0);

        decim_log2 = 4'd2;
        strobe(24'h100, 24'h0);
        strobe(24'h200, 24'h0);
        freeze = 1'b1;
        for (int v = 0; v < 3; v++)
            strobe(24'h300 + 24'(v), 24'h0);
        freeze = 1'b0;
        strobe(24'h1, 24'h0);
        strobe(24'h2, 24'h0);
        strobe(24'h3, 24'h0);
        repeat (LAT + 1) tick();
        chk("freeze_early", 64'(exp_q.size()), 64'd0);
        chk("freeze_level", 64'(level), 64'd0);
`ifdef AUDIO_BUF_AVG_EN
        exp_q.push_back(fr(24'h2, 24'h0));
`else
        exp_q.push_back(fr(24'h4, 24'h0));
`endif
        strobe(24'h4, 24'h0);
        repeat (LAT + 3) tick();
        chk("freeze_one", 64'(exp_q.size()), 64'd0);

        out_ready  = 1'b0;
        decim_log2 = 4'd0;
        strobe(24'hA, 24'h0);
        strobe(24'hB, 24'h0);
        decim_log2 = 4'd3;
        for (int v = 0; v < 5; v++)
            strobe(24'h50 + 24'(v), 24'h0);
        @(negedge clk);
        chk("rw_level", 64'(level), 64'd2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rw_valid", 64'(out_valid), 64'd0);
        chk("rw_level0", 64'(level), 64'd0);
        chk("rw_ovf", 64'(overflow), 64'd0);
        tick();
        out_ready = 1'b1;
        for (int v = 1; v <= 7; v++)
            strobe(24'(v), 24'h0);
        repeat (LAT + 1) tick();
        chk("rw_no_early", 64'(level), 64'd0);
`ifdef AUDIO_BUF_AVG_EN
        exp_q.push_back(fr(24'h4, 24'h0));
`else
        exp_q.push_back(fr(24'h8, 24'h0));
`endif
        strobe(24'h8, 24'h0);
        repeat (LAT + 3) tick();
        chk("rw_one", 64'(exp_q.size()), 64'd0);
        chk("rw_end_level", 64'(level), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
